conv_transposed_3d_scatter_agu: RTL and testbench
=================================================

# conv_transposed_3d_scatter_agu

Address-generation sequencer placed directly upstream of the transposed-3D-convolution datapath. On `start` it walks every input-voxel × kernel-tap pair for one layer in scatter order. For each pair it emits one beat with three addresses: input feature, weight, and output accumulator. It also flags whether the tap lands inside the output volume. The downstream MAC/accumulate stage consumes the beats over a valid/ready handshake. The block uses groups=1, a cubic input, and a cubic kernel.

## Interface
Parameters:
- `IN_CH`, 4: input channels (≥1)
- `OUT_CH`, 4: output channels (≥1)
- `D`, 8: input edge length, so the input is D×D×D (≥1)
- `K`, 3: kernel edge length (≥1)
- `STRIDE`, 1: stride (≥1)
- `PAD`, 0: padding (≥0)
- `OUT_PAD`, 0: output padding (0 ≤ OUT_PAD < STRIDE)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins a layer; ignored while `busy`
- `abort`  in  1  synchronous; kills the run, takes priority over everything except `rst`
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the final beat handshakes
- `m_valid`  out  1  beat valid
- `m_ready`  in  1  downstream accepts the beat
- `m_in_addr`  out  AW_IN  input address, `((ic*D+id)*D+ih)*D+iw`
- `m_w_addr`  out  AW_W  weight address, layout [IC][OC][K][K][K]: `(((ic*OUT_CH+oc)*K+kd)*K+kh)*K+kw`
- `m_out_addr`  out  AW_OUT  output address, `((oc*O+od)*O+oh)*O+ow`; 0 when `m_keep`=0
- `m_keep`  out  1  tap lands inside the output volume
- `m_last`  out  1  final beat of the layer

## Operation
- Output edge: O = (D−1)·STRIDE − 2·PAD + K + OUT_PAD.
- Loop nest, outermost to innermost: oc, ic, id, ih, iw, kd, kh, kw.
  - Every tap produces exactly one beat, including out-of-range taps.
  - Total beats per layer: OUT_CH·IC·D³·K³.
- Output coordinate per axis: o = i·STRIDE − PAD + k, computed signed.
  - `m_keep` = 1 iff 0 ≤ o < O on all three axes.
- `m_last` = 1 only on the beat with every counter at its maximum.
- FSM states and transitions:
  - IDLE: `start` → RUN.
  - RUN: counters advance on each handshake. Handshake on the `m_last` beat → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
- `abort` in any state:
  - → IDLE next cycle; `m_valid`, `busy`, `done` go to 0.
  - Counters clear; no `done` pulse.
  - A beat presented in the same cycle as `abort` counts as not transferred.
- `start` coincident with `done` is ignored.
- Reset values: all outputs 0; FSM IDLE; counters 0.

## Timing
- Latency: `start` at cycle t gives `busy`=1 and `m_valid`=1 with beat 0 at t+1.
- Throughput: 1 beat/cycle while `m_ready`=1.
- Handshake:
  - Transfer when `m_valid`&&`m_ready`.
  - While `m_valid`=1 and `m_ready`=0, all `m_*` hold stable.
  - `m_valid` never drops without a transfer, except on `abort` or `rst`.
- All `m_*` outputs are registered; no combinational path from `m_ready` to any output.
- The final handshake at cycle n gives `done`=1 and `busy`=0 at n+1, and `m_valid`=0 at n+1.
- Asynchronous `rst` mid-run forces all outputs to 0 immediately.

## Structure
- Package `conv_t3d_pkg`:
  - Localparam function for O.
  - Width constants AW_IN = clog2(IC·D³), AW_W = clog2(IC·OUT_CH·K³), AW_OUT = clog2(OUT_CH·O³), each with a minimum of 1.
  - FSM state enum.
- Sub-module `conv_t3d_wrap_counter`:
  - Parameterised modulo-N counter with `en`, `clr`, `wrap` outputs.
  - Eight instances chained by `wrap`.
- Addresses may be computed by multiply or by incremental stride adds. Either way, the output must match the formulas above bit-exactly.

## Test plan
- IC=OC=1, D=2, K=2, STRIDE=2, PAD=0 (O=4), `m_ready`=1:
  - Exactly 64 beats, all `m_keep`=1.
  - Beat 0 is in 0 / w 0 / out 0.
  - Beat 1 is out 1.
  - Beat for iw=1, kw=1 (index 9) is out 3.
  - `m_last` only on beat 63; `done` the next cycle.
- Same config with PAD=1 (O=2):
  - Beat 0 has `m_keep`=0 and `m_out_addr`=0.
  - Tap id=ih=iw=0, kd=kh=kw=1 has `m_keep`=1 and out 0.
- Backpressure: hold `m_ready`=0 for 5 cycles at beat 10.
  - Payload stable for those cycles; beat 10 transfers exactly once; beat count unchanged.
- Random `m_ready` over a full IC=OC=2, D=3, K=3 run:
  - Scoreboard against a reference nested-loop model; 2·2·27·27 = 2916 beats.
- `abort` at beat 20 with `m_valid`=1:
  - `m_valid`=0 next cycle; no `done`.
  - A subsequent `start` restarts at beat 0.
- `start` pulsed mid-run, then `rst` asserted mid-run:
  - The `start` has no effect.
  - On `rst`, all outputs are 0 immediately and the block is IDLE after release.

Source files
------------

// File: rtl/conv_t3d_pkg.sv
// Shared types and elaboration helpers for the transposed-3D-conv scatter address generator.
package conv_t3d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } agu_state_t;

  // Output edge length of a transposed convolution along one axis.
  function automatic int calc_o_edge(input int d, input int k, input int stride,
                                     input int pad, input int out_pad);
    return (d - 1) * stride - 2 * pad + k + out_pad;
  endfunction

  // Address/counter width for n distinct values, never narrower than one bit.
  function automatic int aw_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_t3d_wrap_counter.sv
// Modulo-N counter; wrap is high when an enabled count rolls over from N-1 to 0,
// which lets a chain of these form a nested loop.
module conv_t3d_wrap_counter
  import conv_t3d_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = aw_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic at_max;

  assign at_max = (count == CW'(N - 1));
  assign wrap   = en && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= at_max ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/conv_transposed_3d_scatter_agu.sv
// Scatter-order address sequencer for a transposed 3D convolution: one beat per
// (input voxel, kernel tap) pair carrying input, weight and output addresses.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for start; counters at zero
//   ST_RUN  | presenting beats, advancing on each handshake
//   ST_DONE | one-cycle done pulse after the last beat
module conv_transposed_3d_scatter_agu
  import conv_t3d_pkg::*;
#(
  parameter  int IN_CH   = 4,
  parameter  int OUT_CH  = 4,
  parameter  int D       = 8,
  parameter  int K       = 3,
  parameter  int STRIDE  = 1,
  parameter  int PAD     = 0,
  parameter  int OUT_PAD = 0,
  localparam int O       = calc_o_edge(D, K, STRIDE, PAD, OUT_PAD),
  localparam int AW_IN   = aw_min1(IN_CH * D * D * D),
  localparam int AW_W    = aw_min1(IN_CH * OUT_CH * K * K * K),
  localparam int AW_OUT  = aw_min1(OUT_CH * O * O * O)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AW_IN-1:0]  m_in_addr,
  output logic [AW_W-1:0]   m_w_addr,
  output logic [AW_OUT-1:0] m_out_addr,
  output logic              m_keep,
  output logic              m_last
);

  localparam int CW_OC = aw_min1(OUT_CH);
  localparam int CW_IC = aw_min1(IN_CH);
  localparam int CW_D  = aw_min1(D);
  localparam int CW_K  = aw_min1(K);

  agu_state_t state_q, state_d;

  logic [CW_OC-1:0] c_oc;
  logic [CW_IC-1:0] c_ic;
  logic [CW_D-1:0]  c_id, c_ih, c_iw;
  logic [CW_K-1:0]  c_kd, c_kh, c_kw;
  logic wrap_oc, wrap_ic, wrap_id, wrap_ih, wrap_iw, wrap_kd, wrap_kh, wrap_kw;

  logic hs, accept, load, retire;
  int   od, oh, ow;
  logic              keep_nxt;
  logic [AW_IN-1:0]  in_nxt;
  logic [AW_W-1:0]   w_nxt;
  logic [AW_OUT-1:0] out_nxt;

  // Counters hold the index of the next beat to load, one step ahead of the
  // registered payload, so every m_* output comes straight from a flop.
  assign hs     = m_valid && m_ready;
  assign accept = (state_q == ST_IDLE) && start;
  assign load   = !abort && (accept || (hs && !m_last));
  assign retire = !abort && hs && m_last;

  conv_t3d_wrap_counter #(.N(K)) u_cnt_kw (
    .clk(clk), .rst(rst), .en(load), .clr(abort), .count(c_kw), .wrap(wrap_kw)
  );
  conv_t3d_wrap_counter #(.N(K)) u_cnt_kh (
    .clk(clk), .rst(rst), .en(wrap_kw), .clr(abort), .count(c_kh), .wrap(wrap_kh)
  );
  conv_t3d_wrap_counter #(.N(K)) u_cnt_kd (
    .clk(clk), .rst(rst), .en(wrap_kh), .clr(abort), .count(c_kd), .wrap(wrap_kd)
  );
  conv_t3d_wrap_counter #(.N(D)) u_cnt_iw (
    .clk(clk), .rst(rst), .en(wrap_kd), .clr(abort), .count(c_iw), .wrap(wrap_iw)
  );
  conv_t3d_wrap_counter #(.N(D)) u_cnt_ih (
    .clk(clk), .rst(rst), .en(wrap_iw), .clr(abort), .count(c_ih), .wrap(wrap_ih)
  );
  conv_t3d_wrap_counter #(.N(D)) u_cnt_id (
    .clk(clk), .rst(rst), .en(wrap_ih), .clr(abort), .count(c_id), .wrap(wrap_id)
  );
  conv_t3d_wrap_counter #(.N(IN_CH)) u_cnt_ic (
    .clk(clk), .rst(rst), .en(wrap_id), .clr(abort), .count(c_ic), .wrap(wrap_ic)
  );
  conv_t3d_wrap_counter #(.N(OUT_CH)) u_cnt_oc (
    .clk(clk), .rst(rst), .en(wrap_ic), .clr(abort), .count(c_oc), .wrap(wrap_oc)
  );

  // Output coordinates are signed: negative padding offsets fall outside the volume.
  always_comb begin
    od       = int'(c_id) * STRIDE - PAD + int'(c_kd);
    oh       = int'(c_ih) * STRIDE - PAD + int'(c_kh);
    ow       = int'(c_iw) * STRIDE - PAD + int'(c_kw);
    keep_nxt = (od >= 0) && (od < O) && (oh >= 0) && (oh < O) && (ow >= 0) && (ow < O);
    in_nxt   = AW_IN'(((int'(c_ic) * D + int'(c_id)) * D + int'(c_ih)) * D + int'(c_iw));
    w_nxt    = AW_W'((((int'(c_ic) * OUT_CH + int'(c_oc)) * K + int'(c_kd)) * K
                      + int'(c_kh)) * K + int'(c_kw));
    out_nxt  = keep_nxt ? AW_OUT'(((int'(c_oc) * O + od) * O + oh) * O + ow) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_addr  <= '0;
      m_w_addr   <= '0;
      m_out_addr <= '0;
      m_keep     <= 1'b0;
      m_last     <= 1'b0;
    end else if (abort || retire) begin
      m_in_addr  <= '0;
      m_w_addr   <= '0;
      m_out_addr <= '0;
      m_keep     <= 1'b0;
      m_last     <= 1'b0;
    end else if (load) begin
      m_in_addr  <= in_nxt;
      m_w_addr   <= w_nxt;
      m_out_addr <= out_nxt;
      m_keep     <= keep_nxt;
      // All eight counters at maximum is exactly when the outermost one wraps.
      m_last     <= wrap_oc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if (m_ready && m_last) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    m_valid = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_RUN: begin
        busy    = 1'b1;
        m_valid = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_transposed_3d_scatter_agu.sv
// Bench for the scatter AGU: three configurations checked beat-by-beat against a
// flat-index reference model.
module tb_conv_transposed_3d_scatter_agu;
  import conv_t3d_pkg::*;

  localparam int A_WI = aw_min1(1 * 8);
  localparam int A_WW = aw_min1(1 * 1 * 8);
  localparam int A_WO = aw_min1(1 * 4 * 4 * 4);
  localparam int B_WI = aw_min1(1 * 8);
  localparam int B_WW = aw_min1(1 * 1 * 8);
  localparam int B_WO = aw_min1(1 * 2 * 2 * 2);
  localparam int C_WI = aw_min1(2 * 27);
  localparam int C_WW = aw_min1(2 * 2 * 27);
  localparam int C_WO = aw_min1(2 * 6 * 6 * 6);

  typedef struct {
    int in_a;
    int w_a;
    int out_a;
    int keep;
    int last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_start, a_abort, a_ready, a_busy, a_done, a_valid, a_keep, a_last;
  logic [A_WI-1:0] a_in;
  logic [A_WW-1:0] a_w;
  logic [A_WO-1:0] a_out;
  logic b_start, b_abort, b_ready, b_busy, b_done, b_valid, b_keep, b_last;
  logic [B_WI-1:0] b_in;
  logic [B_WW-1:0] b_w;
  logic [B_WO-1:0] b_out;
  logic c_start, c_abort, c_ready, c_busy, c_done, c_valid, c_keep, c_last;
  logic [C_WI-1:0] c_in;
  logic [C_WW-1:0] c_w;
  logic [C_WO-1:0] c_out;

  conv_transposed_3d_scatter_agu #(
    .IN_CH(1), .OUT_CH(1), .D(2), .K(2), .STRIDE(2), .PAD(0), .OUT_PAD(0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .busy(a_busy), .done(a_done),
    .m_valid(a_valid), .m_ready(a_ready), .m_in_addr(a_in), .m_w_addr(a_w),
    .m_out_addr(a_out), .m_keep(a_keep), .m_last(a_last)
  );

  conv_transposed_3d_scatter_agu #(
    .IN_CH(1), .OUT_CH(1), .D(2), .K(2), .STRIDE(2), .PAD(1), .OUT_PAD(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done),
    .m_valid(b_valid), .m_ready(b_ready), .m_in_addr(b_in), .m_w_addr(b_w),
    .m_out_addr(b_out), .m_keep(b_keep), .m_last(b_last)
  );

  conv_transposed_3d_scatter_agu #(
    .IN_CH(2), .OUT_CH(2), .D(3), .K(3), .STRIDE(2), .PAD(1), .OUT_PAD(1)
  ) u_dut_c (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .busy(c_busy), .done(c_done),
    .m_valid(c_valid), .m_ready(c_ready), .m_in_addr(c_in), .m_w_addr(c_w),
    .m_out_addr(c_out), .m_keep(c_keep), .m_last(c_last)
  );

  int n_checks = 0;
  int n_fail = 0;
  int a_idx = 0, b_idx = 0, c_idx = 0;
  int a_last_cyc = -100;
  bit c_hold = 1'b0;
  int c_h_in, c_h_w, c_h_out, c_h_keep, c_h_last;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: decompose the flat beat index over oc,ic,id,ih,iw,kd,kh,kw.
  function automatic beat_t ref_beat(input int ic_n, input int oc_n, input int d, input int k,
                                     input int s, input int p, input int op, input int idx);
    beat_t b;
    int r, o, total, kw, kh, kd, iw, ih, id, ic, oc, od, oh, ow;
    o     = (d - 1) * s - 2 * p + k + op;
    total = oc_n * ic_n * d * d * d * k * k * k;
    r  = idx;
    kw = r % k; r = r / k;
    kh = r % k; r = r / k;
    kd = r % k; r = r / k;
    iw = r % d; r = r / d;
    ih = r % d; r = r / d;
    id = r % d; r = r / d;
    ic = r % ic_n;
    oc = r / ic_n;
    od = id * s - p + kd;
    oh = ih * s - p + kh;
    ow = iw * s - p + kw;
    b.keep  = (od >= 0 && od < o && oh >= 0 && oh < o && ow >= 0 && ow < o) ? 1 : 0;
    b.in_a  = ((ic * d + id) * d + ih) * d + iw;
    b.w_a   = (((ic * oc_n + oc) * k + kd) * k + kh) * k + kw;
    b.out_a = (b.keep == 1) ? (((oc * o + od) * o + oh) * o + ow) : 0;
    b.last  = (idx == total - 1) ? 1 : 0;
    return b;
  endfunction

  task automatic chk_beat(input string who, input int in_a, input int w_a, input int out_a,
                          input int keep, input int last, input beat_t e);
    chk({who, "_in"}, in_a, e.in_a);
    chk({who, "_w"}, w_a, e.w_a);
    chk({who, "_out"}, out_a, e.out_a);
    chk({who, "_keep"}, keep, e.keep);
    chk({who, "_last"}, last, e.last);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for the negedge and scoreboard every handshake on all three instances.
  task automatic sample();
    beat_t e;
    @(negedge clk);
    if (!rst) begin
      if (a_start && !a_busy && !a_done && !a_abort) a_idx = 0;
      if (b_start && !b_busy && !b_done && !b_abort) b_idx = 0;
      if (c_start && !c_busy && !c_done && !c_abort) c_idx = 0;
      if (a_valid && a_ready && !a_abort) begin
        e = ref_beat(1, 1, 2, 2, 2, 0, 0, a_idx);
        chk_beat("a", int'(a_in), int'(a_w), int'(a_out), int'(a_keep), int'(a_last), e);
        chk("a_keep_all", int'(a_keep), 1);
        if (a_idx == 0) begin
          chk("a_b0_in", int'(a_in), 0);
          chk("a_b0_w", int'(a_w), 0);
          chk("a_b0_out", int'(a_out), 0);
        end
        if (a_idx == 1) chk("a_b1_out", int'(a_out), 1);
        if (a_idx == 9) chk("a_b9_out", int'(a_out), 3);
        if (a_idx == 63) chk("a_b63_last", int'(a_last), 1);
        if (a_last) a_last_cyc = cyc;
        a_idx++;
      end
      if (b_valid && b_ready && !b_abort) begin
        e = ref_beat(1, 1, 2, 2, 2, 1, 0, b_idx);
        chk_beat("b", int'(b_in), int'(b_w), int'(b_out), int'(b_keep), int'(b_last), e);
        if (b_idx == 0) begin
          chk("b_b0_keep", int'(b_keep), 0);
          chk("b_b0_out", int'(b_out), 0);
        end
        if (b_idx == 7) begin
          chk("b_b7_keep", int'(b_keep), 1);
          chk("b_b7_out", int'(b_out), 0);
        end
        b_idx++;
      end
      if (c_hold) begin
        chk("c_hold_valid", int'(c_valid), 1);
        chk("c_hold_in", int'(c_in), c_h_in);
        chk("c_hold_w", int'(c_w), c_h_w);
        chk("c_hold_out", int'(c_out), c_h_out);
        chk("c_hold_keep", int'(c_keep), c_h_keep);
        chk("c_hold_last", int'(c_last), c_h_last);
      end
      c_hold = c_valid && !c_ready && !c_abort;
      c_h_in = int'(c_in); c_h_w = int'(c_w); c_h_out = int'(c_out);
      c_h_keep = int'(c_keep); c_h_last = int'(c_last);
      if (c_valid && c_ready && !c_abort) begin
        e = ref_beat(2, 2, 3, 3, 2, 1, 1, c_idx);
        chk_beat("c", int'(c_in), int'(c_w), int'(c_out), int'(c_keep), int'(c_last), e);
        c_idx++;
      end
    end
  endtask

  task automatic chk_a_zero(input string p);
    chk({p, "_busy"}, int'(a_busy), 0);
    chk({p, "_done"}, int'(a_done), 0);
    chk({p, "_valid"}, int'(a_valid), 0);
    chk({p, "_in"}, int'(a_in), 0);
    chk({p, "_w"}, int'(a_w), 0);
    chk({p, "_out"}, int'(a_out), 0);
    chk({p, "_keep"}, int'(a_keep), 0);
    chk({p, "_last"}, int'(a_last), 0);
  endtask

  task automatic start_a();
    next_cyc();
    a_start = 1'b1;
    a_ready = 1'b1;
    sample();
    chk("a_lat_pre_valid", int'(a_valid), 0);
    next_cyc();
    a_start = 1'b0;
    chk("a_lat_valid", int'(a_valid), 1);
    chk("a_lat_busy", int'(a_busy), 1);
  endtask

  task automatic run_a(input bit with_bp, output int beats);
    bit seen;
    int hold;
    int cap_in, cap_w, cap_out;
    start_a();
    seen = 1'b0;
    hold = 0;
    cap_in = 0; cap_w = 0; cap_out = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (with_bp && a_idx == 10 && hold < 5) begin
        if (hold == 0) begin
          cap_in = int'(a_in); cap_w = int'(a_w); cap_out = int'(a_out);
        end
        a_ready = 1'b0;
        hold++;
      end else begin
        a_ready = 1'b1;
      end
      sample();
      if (!a_ready) begin
        chk("a_bp_valid", int'(a_valid), 1);
        chk("a_bp_in", int'(a_in), cap_in);
        chk("a_bp_w", int'(a_w), cap_w);
        chk("a_bp_out", int'(a_out), cap_out);
      end
      if (a_done) begin
        seen = 1'b1;
        chk("a_done_lat", cyc - a_last_cyc, 1);
        chk("a_done_busy", int'(a_busy), 0);
        chk("a_done_valid", int'(a_valid), 0);
      end
      next_cyc();
    end
    chk("a_done_seen", int'(seen), 1);
    beats = a_idx;
  endtask

  task automatic run_bc(input int sel, input int budget, output int beats);
    bit seen;
    next_cyc();
    if (sel == 1) b_start = 1'b1;
    else          c_start = 1'b1;
    b_ready = 1'b1;
    c_ready = 1'b1;
    sample();
    next_cyc();
    b_start = 1'b0;
    c_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (sel == 2) c_ready = ($urandom_range(0, 1) == 1);
      sample();
      if ((sel == 1 && b_done) || (sel == 2 && c_done)) seen = 1'b1;
      next_cyc();
    end
    chk((sel == 1) ? "b_done_seen" : "c_done_seen", int'(seen), 1);
    beats = (sel == 1) ? b_idx : c_idx;
  endtask

  initial begin
    int beats;
    bit saw_done;
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
    c_start = 1'b0; c_abort = 1'b0; c_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_a_zero("a_rst");
    rst = 1'b0;
    sample();
    chk("a_idle_busy", int'(a_busy), 0);
    chk("a_idle_valid", int'(a_valid), 0);

    run_a(1'b1, beats);
    chk("a_beats", beats, 64);
    sample();
    chk("a_post_busy", int'(a_busy), 0);
    chk("a_post_done", int'(a_done), 0);

    run_bc(1, 400, beats);
    chk("b_beats", beats, 64);
    run_bc(2, 20000, beats);
    chk("c_beats", beats, 2916);

    // Abort with beat 20 on the bus.
    start_a();
    for (int i = 0; i < 100 && a_idx != 20; i++) begin
      sample();
      next_cyc();
    end
    chk("a_abort_pre_valid", int'(a_valid), 1);
    a_abort = 1'b1;
    sample();
    next_cyc();
    a_abort = 1'b0;
    chk("a_abort_valid", int'(a_valid), 0);
    chk("a_abort_busy", int'(a_busy), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (a_done) saw_done = 1'b1;
      next_cyc();
    end
    chk("a_abort_no_done", int'(saw_done), 0);
    run_a(1'b0, beats);
    chk("a_restart_beats", beats, 64);

    // Stray start mid-run, then asynchronous reset mid-run.
    start_a();
    for (int i = 0; i < 100 && a_idx != 30; i++) begin
      sample();
      next_cyc();
    end
    a_start = 1'b1;
    sample();
    next_cyc();
    a_start = 1'b0;
    for (int i = 0; i < 100 && a_idx != 40; i++) begin
      sample();
      next_cyc();
    end
    chk("a_midrun_busy", int'(a_busy), 1);
    #1;
    rst = 1'b1;
    #1;
    chk_a_zero("a_midrst");
    next_cyc();
    next_cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("a_after_rst_busy", int'(a_busy), 0);
      chk("a_after_rst_valid", int'(a_valid), 0);
    end
    run_a(1'b0, beats);
    chk("a_after_rst_beats", beats, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
